// File: rtl/maluch_cpu.sv
// rtl/maluch_cpu.sv - single-cycle 32-bit Maluch core (optional multiplier: MALUCH_MUL_EN)
module maluch_cpu (
  input  logic        clk,
  input  logic        _reset,
  input  logic [31:0] instr_in,
  output logic [31:0] pointer
);

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_HLT = 5'h01;
  localparam logic [4:0] OP_MOV = 5'h02;
  localparam logic [4:0] OP_ADD = 5'h03;
  localparam logic [4:0] OP_SUB = 5'h04;
  localparam logic [4:0] OP_AND = 5'h05;
  localparam logic [4:0] OP_OR  = 5'h06;
  localparam logic [4:0] OP_XOR = 5'h07;
  localparam logic [4:0] OP_NOT = 5'h08;
  localparam logic [4:0] OP_SHL = 5'h09;
  localparam logic [4:0] OP_SHR = 5'h0A;
  localparam logic [4:0] OP_CMP = 5'h0B;
  localparam logic [4:0] OP_JMP = 5'h0C;
  localparam logic [4:0] OP_JZ  = 5'h0D;
  localparam logic [4:0] OP_JNZ = 5'h0E;
  localparam logic [4:0] OP_JC  = 5'h0F;
`ifdef MALUCH_MUL_EN
  localparam logic [4:0] OP_MUL = 5'h10;
`endif

  // Architectural state
  logic [31:0] regs [8];
  logic        flag_z;
  logic        flag_c;
  logic        flag_s;
  logic        halted;

  // Decoded fields
  logic [4:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic        imm_sel;
  logic [15:0] imm16;
  logic        unused_bits;

  assign opcode      = instr_in[31:27];
  assign rd          = instr_in[26:24];
  assign rs          = instr_in[23:21];
  assign imm_sel     = instr_in[20];
  assign imm16       = instr_in[15:0];
  assign unused_bits = ^instr_in[19:16];

  // Operands: A is always R[rd], B is sign-extended immediate or R[rs]
  logic [31:0] op_a;
  logic [31:0] op_b;
  assign op_a = regs[rd];
  assign op_b = imm_sel ? {{16{imm16[15]}}, imm16} : regs[rs];

  // Wide intermediates so carry/shifted-out bits fall out of the arithmetic
  logic [32:0] add_w;
  logic [32:0] shl_w;
  logic [32:0] shr_w;
  assign add_w = {1'b0, op_a} + {1'b0, op_b};
  assign shl_w = {1'b0, op_a} << op_b[4:0];
  assign shr_w = {op_a, 1'b0} >> op_b[4:0];

  logic [31:0] result;
  logic        carry_new;
  logic        reg_we;
  logic        flag_we;
  logic        halt_set;
  logic [31:0] next_pointer;

  // Decode, ALU and next-pointer selection
  always_comb begin
    result       = op_a;
    carry_new    = 1'b0;
    reg_we       = 1'b0;
    flag_we      = 1'b0;
    halt_set     = 1'b0;
    next_pointer = pointer + 32'd1;
    case (opcode)
      OP_HLT: begin
        halt_set     = 1'b1;
        next_pointer = pointer;
      end
      OP_MOV: begin
        result = op_b;
        reg_we = 1'b1;
      end
      OP_ADD: begin
        result    = add_w[31:0];
        carry_new = add_w[32];
        reg_we    = 1'b1;
        flag_we   = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        result    = op_a - op_b;
        carry_new = (op_a < op_b);
        reg_we    = (opcode == OP_SUB);
        flag_we   = 1'b1;
      end
      OP_AND: begin
        result  = op_a & op_b;
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_OR: begin
        result  = op_a | op_b;
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_XOR: begin
        result  = op_a ^ op_b;
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_NOT: begin
        result  = ~op_b;
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
      OP_SHL: begin
        result    = shl_w[31:0];
        carry_new = shl_w[32];
        reg_we    = 1'b1;
        flag_we   = 1'b1;
      end
      OP_SHR: begin
        result    = shr_w[32:1];
        carry_new = shr_w[0];
        reg_we    = 1'b1;
        flag_we   = 1'b1;
      end
      OP_JMP: next_pointer = op_b;
      OP_JZ:  if (flag_z)  next_pointer = op_b;
      OP_JNZ: if (!flag_z) next_pointer = op_b;
      OP_JC:  if (flag_c)  next_pointer = op_b;
`ifdef MALUCH_MUL_EN
      OP_MUL: begin
        result  = op_a * op_b;
        reg_we  = 1'b1;
        flag_we = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Commit register, flag and pointer updates; halt freezes everything but reset
  always_ff @(posedge clk) begin
    if (!_reset) begin
      pointer <= 32'd0;
      for (int i = 0; i < 8; i++) regs[i] <= 32'd0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_s  <= 1'b0;
      halted  <= 1'b0;
    end else if (!halted) begin
      pointer <= next_pointer;
      halted  <= halt_set;
      if (reg_we) regs[rd] <= result;
      if (flag_we) begin
        flag_z <= (result == 32'd0);
        flag_c <= carry_new;
        flag_s <= result[31];
      end
    end
  end

endmodule

// File: tb/tb_maluch_cpu.sv
// tb/tb_maluch_cpu.sv - scoreboard bench for maluch_cpu pointer sequencing
module tb_maluch_cpu;

  logic        clk;
  logic        _reset;
  logic [31:0] instr_in;
  logic [31:0] pointer;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  maluch_cpu dut (
    .clk      (clk),
    ._reset   (_reset),
    .instr_in (instr_in),
    .pointer  (pointer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic i,
                                      input logic [15:0] imm);
    return {op, rd, rs, i, 4'b0000, imm};
  endfunction

  localparam logic [31:0] NOP = 32'h0;

  task automatic apply_reset();
    _reset   = 1'b0;
    instr_in = NOP;
    @(posedge clk); #1;
    _reset   = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] got, e;
    _reset   = 1'b0;
    instr_in = NOP;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(32'd0);
      @(posedge clk); #1;
      got = pointer; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_hold%0d got=%h want=%h", k, got, e); end
    end
    _reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      instr_in = NOP;
      exp_q.push_back(k);
      @(posedge clk); #1;
      got = pointer; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_seq%0d got=%h want=%h", k, got, e); end
    end
    _reset = 1'b0;
    instr_in = enc(5'h0C, 3'd0, 3'd0, 1'b1, 16'h0077);
    exp_q.push_back(32'd0);
    @(posedge clk); #1;
    got = pointer; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_mid got=%h want=%h", got, e); end
    _reset = 1'b1;
  endtask

  task automatic test_branch(input logic [15:0] r2v, input logic [31:0] final_ptr);
    logic [31:0] prog [4];
    logic [31:0] ex   [4];
    logic [31:0] got, e;
    apply_reset();
    prog = '{enc(5'h02, 3'd1, 3'd0, 1'b1, 16'd5),
             enc(5'h02, 3'd2, 3'd0, 1'b1, r2v),
             enc(5'h0B, 3'd1, 3'd2, 1'b0, 16'd0),
             enc(5'h0D, 3'd0, 3'd0, 1'b1, 16'h0040)};
    ex   = '{32'd1, 32'd2, 32'd3, final_ptr};
    for (int k = 0; k < 4; k++) begin
      instr_in = prog[k];
      exp_q.push_back(ex[k]);
      @(posedge clk); #1;
      got = pointer; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL branch_r2_%0d_step%0d got=%h want=%h", r2v, k, got, e); end
    end
  endtask

  task automatic test_jump();
    logic [31:0] prog [7];
    logic [31:0] ex   [7];
    logic [31:0] got, e;
    apply_reset();
    prog = '{enc(5'h02, 3'd3, 3'd0, 1'b1, 16'h0100),
             enc(5'h0C, 3'd0, 3'd3, 1'b0, 16'd0),
             enc(5'h02, 3'd2, 3'd0, 1'b1, 16'h0010),
             enc(5'h03, 3'd2, 3'd2, 1'b0, 16'd0),
             enc(5'h0C, 3'd0, 3'd2, 1'b0, 16'd0),
             enc(5'h0C, 3'd0, 3'd0, 1'b1, 16'hFFFF),
             NOP};
    ex   = '{32'd1, 32'h100, 32'h101, 32'h102, 32'h20, 32'hFFFF_FFFF, 32'd0};
    for (int k = 0; k < 7; k++) begin
      instr_in = prog[k];
      exp_q.push_back(ex[k]);
      @(posedge clk); #1;
      got = pointer; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL jump_step%0d got=%h want=%h", k, got, e); end
    end
  endtask

  task automatic test_carry();
    logic [31:0] prog [17];
    logic [31:0] ex   [17];
    logic [31:0] got, e;
    apply_reset();
    prog = '{enc(5'h02, 3'd1, 3'd0, 1'b1, 16'd0),      // MOV r1,#0
             enc(5'h04, 3'd1, 3'd0, 1'b1, 16'd1),      // SUB r1,#1 -> borrow
             enc(5'h0F, 3'd0, 3'd0, 1'b1, 16'h0020),   // JC taken
             enc(5'h0B, 3'd1, 3'd0, 1'b1, 16'hFFFF),   // CMP r1,#-1 -> Z
             enc(5'h0D, 3'd0, 3'd0, 1'b1, 16'h0030),   // JZ taken
             enc(5'h02, 3'd4, 3'd0, 1'b1, 16'h7FFF),   // MOV r4,#0x7FFF
             enc(5'h03, 3'd4, 3'd0, 1'b1, 16'd1),      // ADD r4,#1 -> no carry
             enc(5'h0F, 3'd0, 3'd0, 1'b1, 16'h0050),   // JC not taken
             enc(5'h0E, 3'd0, 3'd0, 1'b1, 16'h0070),   // JNZ taken
             enc(5'h02, 3'd5, 3'd0, 1'b1, 16'd3),      // MOV r5,#3
             enc(5'h0A, 3'd5, 3'd0, 1'b1, 16'd1),      // SHR r5,#1 -> C=1
             enc(5'h0F, 3'd0, 3'd0, 1'b1, 16'h0080),   // JC taken
             enc(5'h09, 3'd5, 3'd0, 1'b1, 16'd0),      // SHL r5,#0 -> C=0
             enc(5'h0F, 3'd0, 3'd0, 1'b1, 16'h0090),   // JC not taken
             enc(5'h07, 3'd5, 3'd5, 1'b0, 16'd0),      // XOR r5,r5 -> Z
             enc(5'h0D, 3'd0, 3'd0, 1'b1, 16'h00A0),   // JZ taken
             enc(5'h0C, 3'd0, 3'd0, 1'b1, 16'h8000)};  // JMP sign-extended
    ex   = '{32'd1, 32'd2, 32'h20, 32'h21, 32'h30, 32'h31, 32'h32, 32'h33, 32'h70,
             32'h71, 32'h72, 32'h80, 32'h81, 32'h82, 32'h83, 32'hA0, 32'hFFFF_8000};
    for (int k = 0; k < 17; k++) begin
      instr_in = prog[k];
      exp_q.push_back(ex[k]);
      @(posedge clk); #1;
      got = pointer; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL carry_step%0d got=%h want=%h", k, got, e); end
    end
  endtask

  task automatic test_halt();
    logic [31:0] got, e;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      instr_in = NOP;
      exp_q.push_back(k + 1);
      @(posedge clk); #1;
      got = pointer; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL halt_pre%0d got=%h want=%h", k, got, e); end
    end
    instr_in = enc(5'h01, 3'd0, 3'd0, 1'b0, 16'd0);
    exp_q.push_back(32'd2);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      got = pointer; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL halt_hold%0d got=%h want=%h", k, got, e); end
      instr_in = (k % 2 == 0) ? enc(5'h0C, 3'd0, 3'd0, 1'b1, 16'h0055) : $urandom();
      exp_q.push_back(32'd2);
      @(posedge clk); #1;
    end
    void'(exp_q.pop_front());
    _reset   = 1'b0;
    instr_in = NOP;
    exp_q.push_back(32'd0);
    @(posedge clk); #1;
    got = pointer; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL halt_reset got=%h want=%h", got, e); end
    _reset = 1'b1;
    exp_q.push_back(32'd1);
    @(posedge clk); #1;
    got = pointer; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL halt_release got=%h want=%h", got, e); end
  endtask

  task automatic test_mul();
    logic [31:0] prog [4];
    logic [31:0] ex   [4];
    logic [31:0] got, e;
    logic [31:0] jz_target;
`ifdef MALUCH_MUL_EN
    jz_target = 32'h60;
`else
    jz_target = 32'd4;
`endif
    apply_reset();
    prog = '{enc(5'h02, 3'd1, 3'd0, 1'b1, 16'd6),
             enc(5'h10, 3'd1, 3'd0, 1'b1, 16'd7),
             enc(5'h0B, 3'd1, 3'd0, 1'b1, 16'd42),
             enc(5'h0D, 3'd0, 3'd0, 1'b1, 16'h0060)};
    ex   = '{32'd1, 32'd2, 32'd3, jz_target};
    for (int k = 0; k < 4; k++) begin
      instr_in = prog[k];
      exp_q.push_back(ex[k]);
      @(posedge clk); #1;
      got = pointer; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL mul_step%0d got=%h want=%h", k, got, e); end
    end
  endtask

  initial begin
    _reset   = 1'b0;
    instr_in = NOP;
    #1;
    test_reset();
    test_branch(16'd5, 32'h40);
    test_branch(16'd6, 32'd4);
    test_jump();
    test_carry();
    test_halt();
    test_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maluch_cpu.md
# maluch_cpu

Single-cycle 32-bit processor core for the Maluch design. It fetches one instruction per clock from an external instruction memory. The instruction pointer drives the fetch address and the instruction word is returned combinationally. Internally it comprises an instruction-pointer counter, a decoder, an 8-entry register file and an ALU with flags; only the pointer is visible externally.

## Interface
- No parameters.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `_reset`  in  1  synchronous, active-low reset.
- `instr_in`  in  32  instruction word at address `pointer`, valid combinationally in the same cycle.
- `pointer`  out  32  instruction pointer (word address), driven directly from the counter register.

## Operation
- Instruction fields:
  - `[31:27]` opcode.
  - `[26:24]` rd.
  - `[23:21]` rs.
  - `[20]` I.
  - `[15:0]` imm16.
  - Other bits are ignored.
- Operand B is sign-extended imm16 when I=1, otherwise R[rs].
- State: R0–R7 (32 bit, all writable, no hardwired zero), flags Z/C/S, halted bit, pointer.
- Opcodes (result written to rd unless noted):
  - 0x00 NOP.
  - 0x01 HLT.
  - 0x02 MOV: rd=B.
  - 0x03 ADD.
  - 0x04 SUB: rd-B.
  - 0x05 AND.
  - 0x06 OR.
  - 0x07 XOR.
  - 0x08 NOT: rd=~B.
  - 0x09 SHL: rd<<B[4:0].
  - 0x0A SHR (logical): rd>>B[4:0].
  - 0x0B CMP: rd-B, flags only.
  - 0x0C JMP.
  - 0x0D JZ.
  - 0x0E JNZ.
  - 0x0F JC.
  - 0x10 MUL (see Configuration).
  - All other opcodes execute as NOP.
- Jumps are absolute: when taken, pointer ← B; otherwise pointer ← pointer+1.
- Arithmetic is 32-bit modulo 2^32. Pointer increment wraps 0xFFFFFFFF→0.
- Flag rules:
  - ADD, SUB, AND, OR, XOR, NOT, SHL, SHR, CMP and MUL update Z (result==0) and S (result[31]).
  - C per operation:
    - ADD: carry-out.
    - SUB/CMP: borrow (rd <u B).
    - SHL/SHR: last bit shifted out, 0 when amount is 0.
    - Logic ops and MUL: C=0.
  - MOV, NOP, HLT and jumps leave flags unchanged.
- HLT sets halted. While halted, pointer, registers and flags are frozen; only reset clears halted.

## Timing
- Single cycle. Decode, ALU and next-pointer logic are combinational on `instr_in`. Register write, flag update and pointer update all commit on the same rising edge.
- A result written at edge N is readable by the instruction executed in cycle N+1, with no hazards.
- Register file: 2 combinational read ports, 1 synchronous write port.
- Reset (`_reset`=0 at a rising edge), including mid-program or while halted:
  - pointer=0, R0–R7=0, Z=C=S=0, halted=0.
  - Reset has priority over any instruction in that cycle.
- Register and flag state is undefined until the first reset edge; `pointer` is defined only after reset.

## Configuration
- `MALUCH_MUL_EN` defined: opcode 0x10 computes rd = low 32 bits of rd*B (unsigned), updates Z/S and clears C.
- Not defined: opcode 0x10 is a NOP with no register or flag change, and no multiplier is synthesized.

## Test plan
- Reset/sequencing: hold `_reset` low 2 edges → pointer=0. Release with NOPs → pointer 1, 2, 3 on successive edges. Pull reset low at pointer=3 → pointer=0 at the next edge.
- Compare/branch: MOV r1,#5; MOV r2,#5; CMP r1,r2; JZ #0x40 → pointer=0x40 after the 4th edge. Repeat with r2=6 → pointer=4.
- Register jump and wrap: MOV r3,#0x100; JMP r3 → pointer=0x100. JMP #-1 (imm 0xFFFF) then NOP → pointer 0xFFFFFFFF then 0.
- Carry/borrow and sign extension:
  - MOV r1,#0; SUB r1,#1; JC #0x20 → taken (pointer=0x20).
  - CMP r1,#-1; JZ #0x30 → taken.
  - MOV r4,#0x7FFF; ADD r4,#1; JC #0x50 → not taken.
- Halt: HLT at pointer=2 → pointer stays 2 for 10 edges regardless of `instr_in`. Reset → 0.
- MUL: with `MALUCH_MUL_EN`, MOV r1,#6; MUL r1,#7; CMP r1,#42; JZ #0x60 → taken. Without the macro → not taken (r1 stays 6).
